led_gray_ctrl: RTL and testbench

LED_GRAY_CTRL -- requirements
Module: led_gray_ctrl

---
 rtl/led_gray_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_led_gray_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_gray_ctrl.sv
// led_gray_ctrl: register-programmed LED pattern engine with direct, gray-count,
// blink and bouncing-scan modes, stepped by a programmable prescaler.
//
// scan state | meaning
// SCAN_UP    | scan position moving toward NUM_LEDS-1
// SCAN_DOWN  | scan position moving toward 0
module led_gray_ctrl #(
  parameter int NUM_LEDS   = 8,
  parameter int PRESCALE_W = 32,
  parameter int ADDR_W     = 4
) (
  input  logic                S_AXI_ACLK,
  input  logic                S_AXI_ARESETN,
  input  logic                slv_reg_wren,
  input  logic [ADDR_W-1:0]   axi_awaddr,
  input  logic [31:0]         S_AXI_WDATA,
  input  logic                slv_reg_rden,
  input  logic [ADDR_W-1:0]   axi_araddr,
  output logic [31:0]         rdata,
  output logic [NUM_LEDS-1:0] LED,
  output logic                tick
);

  localparam int POS_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'd0,
    MODE_GRAY   = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_SCAN   = 2'd3
  } mode_e;

  typedef enum logic {
    SCAN_UP   = 1'b0,
    SCAN_DOWN = 1'b1
  } scan_e;

  logic [NUM_LEDS-1:0]   data_q, data_d;
  mode_e                 mode_q, mode_d;
  logic                  en_q, en_d;
  logic [PRESCALE_W-1:0] period_q, period_d;
  logic [PRESCALE_W-1:0] tmr_q, tmr_d;
  logic [NUM_LEDS-1:0]   seq_q, seq_d;
  logic                  phase_q, phase_d;
  logic [POS_W-1:0]      pos_q, pos_d;
  scan_e                 scan_q, scan_d;
  logic [NUM_LEDS-1:0]   led_d;
  logic [31:0]           rd_mux;
  logic [1:0]            wr_idx, rd_idx;
  logic                  data_wr, ctrl_wr, period_wr;
  logic                  mode_chg, step;
  logic                  unused_bits;

  assign wr_idx    = axi_awaddr[3:2];
  assign rd_idx    = axi_araddr[3:2];
  assign data_wr   = slv_reg_wren && (wr_idx == 2'd0);
  assign ctrl_wr   = slv_reg_wren && (wr_idx == 2'd1);
  assign period_wr = slv_reg_wren && (wr_idx == 2'd2);

  assign unused_bits = ^{axi_awaddr, axi_araddr, S_AXI_WDATA};

  // The timer counts down from PERIOD; reaching zero is the step point.
  // CTRL/PERIOD writes reload it and swallow any step due in that cycle.
  assign step     = en_q && (tmr_q == '0) && !ctrl_wr && !period_wr;
  assign mode_chg = ctrl_wr && (mode_e'(S_AXI_WDATA[1:0]) != mode_q);

  always_comb begin
    data_d   = data_wr   ? S_AXI_WDATA[NUM_LEDS-1:0]   : data_q;
    mode_d   = ctrl_wr   ? mode_e'(S_AXI_WDATA[1:0])   : mode_q;
    en_d     = ctrl_wr   ? S_AXI_WDATA[2]              : en_q;
    period_d = period_wr ? S_AXI_WDATA[PRESCALE_W-1:0] : period_q;

    tmr_d = tmr_q;
    if (ctrl_wr || period_wr || !en_q) begin
      tmr_d = period_d;
    end else if (tmr_q == '0) begin
      tmr_d = period_q;
    end else begin
      tmr_d = tmr_q - PRESCALE_W'(1);
    end
  end

  always_comb begin
    seq_d   = seq_q;
    phase_d = phase_q;
    if (mode_chg) begin
      seq_d   = '0;
      phase_d = 1'b1;
    end else if (step) begin
      seq_d   = seq_q + NUM_LEDS'(1);
      phase_d = ~phase_q;
    end
  end

  // Ends of the bounce are visited once: the turn-around step moves away
  // from the end immediately instead of dwelling there.
  always_comb begin
    scan_d = scan_q;
    pos_d  = pos_q;
    if (mode_chg) begin
      scan_d = SCAN_UP;
      pos_d  = '0;
    end else if (step && (NUM_LEDS > 1)) begin
      case (scan_q)
        SCAN_UP: begin
          if (pos_q == POS_W'(NUM_LEDS - 1)) begin
            scan_d = SCAN_DOWN;
            pos_d  = pos_q - POS_W'(1);
          end else begin
            pos_d  = pos_q + POS_W'(1);
          end
        end
        SCAN_DOWN: begin
          if (pos_q == '0) begin
            scan_d = SCAN_UP;
            pos_d  = pos_q + POS_W'(1);
          end else begin
            pos_d  = pos_q - POS_W'(1);
          end
        end
        default: scan_d = SCAN_UP;
      endcase
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      scan_q <= SCAN_UP;
    end else begin
      scan_q <= scan_d;
    end
  end

  // LED is built from next-state values so it moves on the same edge as
  // the write or step that caused the change.
  always_comb begin
    led_d = data_d;
    case (mode_d)
      MODE_DIRECT: led_d = data_d;
      MODE_GRAY:   led_d = seq_d ^ (seq_d >> 1);
      MODE_BLINK:  led_d = phase_d ? data_d : '0;
      MODE_SCAN:   led_d = NUM_LEDS'(1) << pos_d;
      default:     led_d = data_d;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    case (rd_idx)
      2'd0:    rd_mux = 32'(data_q);
      2'd1:    rd_mux = {29'b0, en_q, mode_q};
      2'd2:    rd_mux = 32'(period_q);
      default: rd_mux = {16'(seq_q), 16'(LED)};
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      data_q   <= '0;
      mode_q   <= MODE_DIRECT;
      en_q     <= 1'b0;
      period_q <= '0;
      tmr_q    <= '0;
      seq_q    <= '0;
      phase_q  <= 1'b1;
      pos_q    <= '0;
      LED      <= '0;
      rdata    <= '0;
      tick     <= 1'b0;
    end else begin
      data_q   <= data_d;
      mode_q   <= mode_d;
      en_q     <= en_d;
      period_q <= period_d;
      tmr_q    <= tmr_d;
      seq_q    <= seq_d;
      phase_q  <= phase_d;
      pos_q    <= pos_d;
      LED      <= led_d;
      tick     <= step;
      if (slv_reg_rden) begin
        rdata <= rd_mux;
      end
    end
  end

endmodule

// File: tb/tb_led_gray_ctrl.sv
// Directed bench for led_gray_ctrl: an 8-LED and a 4-LED instance share the
// same register bus so both widths see identical traffic.
module tb_led_gray_ctrl;

  logic        clk;
  logic        resetn;
  logic        wren;
  logic [3:0]  awaddr;
  logic [31:0] wdata;
  logic        rden;
  logic [3:0]  araddr;
  logic [31:0] rdata, rdata4;
  logic [7:0]  led;
  logic [3:0]  led4;
  logic        tick, tick4;

  int vectors = 0;
  int errors  = 0;

  led_gray_ctrl #(.NUM_LEDS(8), .PRESCALE_W(32), .ADDR_W(4)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(resetn),
    .slv_reg_wren(wren), .axi_awaddr(awaddr), .S_AXI_WDATA(wdata),
    .slv_reg_rden(rden), .axi_araddr(araddr),
    .rdata(rdata), .LED(led), .tick(tick)
  );

  led_gray_ctrl #(.NUM_LEDS(4), .PRESCALE_W(32), .ADDR_W(4)) dut4 (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(resetn),
    .slv_reg_wren(wren), .axi_awaddr(awaddr), .S_AXI_WDATA(wdata),
    .slv_reg_rden(rden), .axi_araddr(araddr),
    .rdata(rdata4), .LED(led4), .tick(tick4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    wren = 1'b1; awaddr = a; wdata = d;
    cyc(1);
    wren = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    rden = 1'b1; araddr = a;
    cyc(1);
    rden = 1'b0;
    d = rdata;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    logic [31:0] addrs [4];
    addrs = '{32'h0, 32'h4, 32'h8, 32'hC};
    resetn = 1'b0;
    cyc(3);
    vectors++; if (led !== 8'h00) begin $display("FAIL reset_led: got %h want 00", led); errors++; end
    vectors++; if (led4 !== 4'h0) begin $display("FAIL reset_led4: got %h want 0", led4); errors++; end
    vectors++; if (rdata !== 32'h0) begin $display("FAIL reset_rdata: got %h want 0", rdata); errors++; end
    vectors++; if (tick !== 1'b0) begin $display("FAIL reset_tick: got %b want 0", tick); errors++; end
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rd(addrs[i][3:0], r);
      vectors++;
      if (r !== 32'h0) begin $display("FAIL reset_reg%0d: got %h want 00000000", i, r); errors++; end
    end
  endtask

  task automatic test_direct();
    logic [31:0] r;
    wr(4'h0, 32'h0000_00A5);
    vectors++; if (led !== 8'hA5) begin $display("FAIL direct_led: got %h want a5", led); errors++; end
    vectors++; if (led4 !== 4'h5) begin $display("FAIL direct_led4: got %h want 5", led4); errors++; end
    rd(4'h0, r);
    vectors++; if (r !== 32'h0000_00A5) begin $display("FAIL direct_read: got %h want 000000a5", r); errors++; end
    cyc(3);
    vectors++; if (rdata !== 32'h0000_00A5) begin $display("FAIL rdata_hold: got %h want 000000a5", rdata); errors++; end
  endtask

  task automatic test_regs();
    logic [31:0] r;
    wr(4'h0, 32'hFFFF_FF3C);
    rd(4'h0, r);
    vectors++; if (r !== 32'h0000_003C) begin $display("FAIL data_mask: got %h want 0000003c", r); errors++; end
    wr(4'h8, 32'h1234_5678);
    rd(4'h8, r);
    vectors++; if (r !== 32'h1234_5678) begin $display("FAIL period_rw: got %h want 12345678", r); errors++; end
    wr(4'h4, 32'hFFFF_FFF8);
    rd(4'h4, r);
    vectors++; if (r !== 32'h0) begin $display("FAIL ctrl_mask: got %h want 00000000", r); errors++; end
    wr(4'hC, 32'hDEAD_BEEF);
    rd(4'hC, r);
    vectors++; if (r !== 32'h0000_003C) begin $display("FAIL status_ro: got %h want 0000003c", r); errors++; end
    wren = 1'b1; awaddr = 4'h0; wdata = 32'h11;
    rden = 1'b1; araddr = 4'h0;
    cyc(1);
    wren = 1'b0; rden = 1'b0;
    vectors++; if (rdata !== 32'h0000_003C) begin $display("FAIL rw_same_cycle: got %h want 0000003c", rdata); errors++; end
    vectors++; if (led !== 8'h11) begin $display("FAIL rw_led: got %h want 11", led); errors++; end
    rd(4'h0, r);
    vectors++; if (r !== 32'h0000_0011) begin $display("FAIL rw_after: got %h want 00000011", r); errors++; end
  endtask

  task automatic test_gray();
    logic [7:0] s, g, prev;
    wr(4'h8, 32'd3);
    wr(4'h4, 32'h5);
    vectors++; if (led !== 8'h00) begin $display("FAIL gray_start: got %h want 00", led); errors++; end
    vectors++; if (tick !== 1'b0) begin $display("FAIL gray_start_tick: got %b want 0", tick); errors++; end
    prev = 8'h00;
    for (int k = 1; k <= 256; k++) begin
      for (int c = 1; c <= 4; c++) begin
        cyc(1);
        vectors++;
        if (tick !== (c == 4)) begin
          $display("FAIL gray_tick k=%0d c=%0d: got %b want %b", k, c, tick, (c == 4)); errors++;
        end
      end
      s = 8'(k);
      g = s ^ (s >> 1);
      vectors++;
      if (led !== g) begin $display("FAIL gray_led k=%0d: got %h want %h", k, led, g); errors++; end
      vectors++;
      if ($countones(prev ^ led) != 1) begin
        $display("FAIL gray_onebit k=%0d: got %h after %h want 1 bit change", k, led, prev); errors++;
      end
      prev = led;
    end
  endtask

  task automatic test_ctrl_collision();
    cyc(3);
    wr(4'h4, 32'h5);
    vectors++; if (led !== 8'h00) begin $display("FAIL collide_led: got %h want 00", led); errors++; end
    vectors++; if (tick !== 1'b0) begin $display("FAIL collide_tick: got %b want 0", tick); errors++; end
    for (int c = 1; c <= 4; c++) begin
      cyc(1);
      vectors++;
      if (tick !== (c == 4)) begin $display("FAIL collide_next_tick c=%0d: got %b want %b", c, tick, (c == 4)); errors++; end
    end
    vectors++; if (led !== 8'h01) begin $display("FAIL collide_next_led: got %h want 01", led); errors++; end
    wr(4'h4, 32'h5);
    vectors++; if (led !== 8'h01) begin $display("FAIL same_mode_hold: got %h want 01", led); errors++; end
    cyc(4);
    vectors++; if (led !== 8'h03) begin $display("FAIL same_mode_cont: got %h want 03", led); errors++; end
    vectors++; if (tick !== 1'b1) begin $display("FAIL same_mode_tick: got %b want 1", tick); errors++; end
  endtask

  task automatic test_blink();
    logic [7:0] e;
    wr(4'h8, 32'd0);
    wr(4'h0, 32'h0F);
    wr(4'h4, 32'h6);
    vectors++; if (led !== 8'h0F) begin $display("FAIL blink_start: got %h want 0f", led); errors++; end
    vectors++; if (led4 !== 4'hF) begin $display("FAIL blink_start4: got %h want f", led4); errors++; end
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      e = (i % 2 == 0) ? 8'h00 : 8'h0F;
      vectors++; if (led !== e) begin $display("FAIL blink_led i=%0d: got %h want %h", i, led, e); errors++; end
      vectors++; if (tick !== 1'b1) begin $display("FAIL blink_tick i=%0d: got %b want 1", i, tick); errors++; end
    end
  endtask

  task automatic test_scan();
    logic [3:0] exp4 [7];
    logic [7:0] exp8 [7];
    exp4 = '{4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2};
    exp8 = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    wr(4'h4, 32'h7);
    vectors++; if (led4 !== 4'h1) begin $display("FAIL scan_start4: got %h want 1", led4); errors++; end
    vectors++; if (led !== 8'h01) begin $display("FAIL scan_start8: got %h want 01", led); errors++; end
    for (int i = 0; i < 7; i++) begin
      cyc(1);
      vectors++; if (led4 !== exp4[i]) begin $display("FAIL scan_led4 i=%0d: got %h want %h", i, led4, exp4[i]); errors++; end
      vectors++; if (led !== exp8[i]) begin $display("FAIL scan_led8 i=%0d: got %h want %h", i, led, exp8[i]); errors++; end
    end
    wr(4'h4, 32'h3);
    for (int i = 0; i < 5; i++) begin
      vectors++; if (led4 !== 4'h2) begin $display("FAIL freeze_led4 i=%0d: got %h want 2", i, led4); errors++; end
      vectors++; if (led !== 8'h80) begin $display("FAIL freeze_led8 i=%0d: got %h want 80", i, led); errors++; end
      vectors++; if (tick4 !== 1'b0) begin $display("FAIL freeze_tick i=%0d: got %b want 0", i, tick4); errors++; end
      cyc(1);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    logic [31:0] addrs [4];
    addrs = '{32'h0, 32'h4, 32'h8, 32'hC};
    wr(4'h4, 32'h5);
    cyc(5);
    resetn = 1'b0;
    wren = 1'b1; awaddr = 4'h0; wdata = 32'h77;
    rden = 1'b1; araddr = 4'hC;
    cyc(1);
    resetn = 1'b1; wren = 1'b0; rden = 1'b0;
    vectors++; if (led !== 8'h00) begin $display("FAIL midrst_led: got %h want 00", led); errors++; end
    vectors++; if (led4 !== 4'h0) begin $display("FAIL midrst_led4: got %h want 0", led4); errors++; end
    vectors++; if (rdata !== 32'h0) begin $display("FAIL midrst_rdata: got %h want 0", rdata); errors++; end
    vectors++; if (tick !== 1'b0) begin $display("FAIL midrst_tick: got %b want 0", tick); errors++; end
    for (int i = 0; i < 4; i++) begin
      rd(addrs[i][3:0], r);
      vectors++;
      if (r !== 32'h0) begin $display("FAIL midrst_reg%0d: got %h want 00000000", i, r); errors++; end
    end
    cyc(3);
    vectors++; if (led !== 8'h00) begin $display("FAIL midrst_idle_led: got %h want 00", led); errors++; end
    vectors++; if (tick !== 1'b0) begin $display("FAIL midrst_idle_tick: got %b want 0", tick); errors++; end
  endtask

  initial begin
    resetn = 1'b0; wren = 1'b0; awaddr = '0; wdata = '0;
    rden = 1'b0; araddr = '0;
    #1;
    test_reset();
    test_direct();
    test_regs();
    test_gray();
    test_ctrl_collision();
    test_blink();
    test_scan();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
